// File: rtl/bcd_pkg.sv
// bcd_pkg
// Shared definitions for the serial packed-BCD adder: digit width, decimal
// limits, the digit type and the controller state encoding.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX     = 9;
  localparam int BCD_CORR    = 6;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_state_e;

endpackage

// File: rtl/bcd_serial_adder_cell.sv
// bcd_digit_cell
// Combinational single-digit decimal adder with +6 correction.
// Ports:
//   ad, bd : BCD digits to add
//   ci     : decimal carry in
//   d      : corrected BCD result digit
//   co     : decimal carry out (raw sum exceeded 9)
//   bad    : either input digit is not a valid BCD digit (>9)
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  bcd_digit_t ad,
  input  bcd_digit_t bd,
  input  logic       ci,
  output bcd_digit_t d,
  output logic       co,
  output logic       bad
);

  logic [4:0] rawSum;
  logic [4:0] corrSum;

  assign rawSum  = {1'b0, ad} + {1'b0, bd} + {4'b0000, ci};
  // Only the low nibble of the corrected sum is kept; the wrap is intended.
  assign corrSum = rawSum + 5'(BCD_CORR);
  assign co      = (rawSum > 5'(BCD_MAX));
  assign d       = co ? corrSum[3:0] : rawSum[3:0];
  assign bad     = (ad > 4'(BCD_MAX)) || (bd > 4'(BCD_MAX));

endmodule

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder
// Multi-digit packed-BCD adder, one decimal digit per clock, LSD first.
// Optional subtract mode is compiled in when macro BCD_SUB_EN is defined.
// Ports:
//   clk, rst : clock (rising edge), synchronous active-high reset
//   start    : request an operation, sampled only while ready=1
//   a, b     : packed BCD operands, digit 0 in bits [3:0]
//   cin      : decimal carry into digit 0
//   sub      : (BCD_SUB_EN only) 1 = A - B, latched at accept
//   ready    : idle, start will be accepted
//   done     : one-cycle pulse, sum/cout/err valid
//   sum      : packed BCD result, held until the next accept
//   cout     : decimal carry out of the top digit (no-borrow in subtract)
//   err      : some latched operand digit was greater than 9
//
// state | meaning
// IDLE  | ready=1, waiting for start; latches operands on accept
// RUN   | one digit per cycle, index 0..DIGITS-1
// DONE  | done pulse for one cycle, results stable
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
`ifdef BCD_SUB_EN
  input  logic                  sub,
`endif
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [1:0]          state;
  logic [IDX_W-1:0]    idx;
  logic                carry;
  logic [4*DIGITS-1:0] aSh;
  logic [4*DIGITS-1:0] bSh;
  logic [4*DIGITS+3:0] sumCat;
  bcd_digit_t          bdRaw;
  bcd_digit_t          bdEff;
  bcd_digit_t          dig;
  logic                carryNext;
  logic                cellBad;
  logic                digitBad;

`ifdef BCD_SUB_EN
  logic subL;
  // 9s complement of B turns subtraction into addition with a forced carry.
  assign bdEff    = subL ? (4'(BCD_MAX) - bdRaw) : bdRaw;
  // Invalid B digits are judged before complementing.
  assign digitBad = cellBad || (bdRaw > 4'(BCD_MAX));
`else
  assign bdEff    = bdRaw;
  assign digitBad = cellBad;
`endif

  // Operands shift right so the digit being processed is always at [3:0].
  assign bdRaw  = bSh[3:0];
  // Result digits enter at the top and reach their final place after DIGITS shifts.
  assign sumCat = {dig, sum};

  bcd_digit_cell uCell (
    .ad  (aSh[3:0]),
    .bd  (bdEff),
    .ci  (carry),
    .d   (dig),
    .co  (carryNext),
    .bad (cellBad)
  );

  assign ready = (state == ST_IDLE);
  assign done  = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      carry <= 1'b0;
      aSh   <= '0;
      bSh   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
`ifdef BCD_SUB_EN
      subL  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            aSh   <= a;
            bSh   <= b;
            sum   <= '0;
            err   <= 1'b0;
            idx   <= '0;
`ifdef BCD_SUB_EN
            subL  <= sub;
            carry <= sub ? 1'b1 : cin;
`else
            carry <= cin;
`endif
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum   <= sumCat[4*DIGITS+3:4];
          aSh   <= aSh >> 4;
          bSh   <= bSh >> 4;
          carry <= carryNext;
          err   <= err || digitBad;
          if (idx == LAST_IDX) begin
            cout  <= carryNext;
            state <= ST_DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
